// File: rtl/spi_pkg.sv
// Shared command-field constants and FSM encoding for the SPI register controller.
package spi_pkg;

    localparam int CMD_WR_BIT  = 7;
    localparam int CMD_RSV_MSB = 6;
    localparam int CMD_RSV_LSB = 4;
    localparam int CMD_ADDR_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR    = 2'd1,
        RD    = 2'd2,
        DRAIN = 2'd3
    } state_e;

    function automatic logic cmd_rsv_ok(input logic [7:0] cmd);
        return cmd[CMD_RSV_MSB:CMD_RSV_LSB] == '0;
    endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Byte stream from the SPI receiver plus the transmit-load path back to it.
interface spi_reg_ctrl_if;

    logic [7:0] byte_in;
    logic       byte_val;
    logic       byte_rdy;
    logic [7:0] tx_data;
    logic       tx_load;

    modport master (output byte_in, byte_val, input byte_rdy, tx_data, tx_load);
    modport slave  (input byte_in, byte_val, output byte_rdy, tx_data, tx_load);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, reset to RST_VAL.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ff_q <= {2{RST_VAL}};
        else     ff_q <= {ff_q[0], d_i};
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI command sequencer: decodes cs-framed command/data bytes into register
// file writes and read-data loads for the transmit side.
module spi_reg_ctrl
    import spi_pkg::*;
#(
    parameter int         NUM_REGS  = 16,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    spi_reg_ctrl_if.slave         bus,
    output logic [8*NUM_REGS-1:0] reg_q,
    output logic                  wr_pulse,
    output logic [3:0]            wr_addr,
    output logic [3:0]            err_cnt
);

    localparam int PTR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic                           cs_s;
    state_e                         state_q;
    logic [PTR_W-1:0]               ptr_q;
    logic [NUM_REGS-1:0][7:0]       regs_q;
    logic [7:0]                     tx_data_q;
    logic                           tx_load_q;
    logic                           wr_pulse_q;
    logic [3:0]                     wr_addr_q;
    logic [3:0]                     err_q;
    logic                           rdy_q;

    logic                           accept;
    logic [CMD_ADDR_W-1:0]          cmd_addr;
    logic [PTR_W-1:0]               cmd_ptr;
    logic [PTR_W-1:0]               ptr_inc;
    logic                           cmd_legal;

    // Reset to 1 so a reset mid-frame makes the next in-frame byte a command.
    sync_2ff #(.RST_VAL(1'b1)) u_cs_sync (
        .clk (clk),
        .rst (rst),
        .d_i (cs),
        .q_o (cs_s)
    );

    assign accept    = bus.byte_val & rdy_q;
    assign cmd_addr  = bus.byte_in[CMD_ADDR_W-1:0];
    assign cmd_ptr   = cmd_addr[PTR_W-1:0];
    assign ptr_inc   = ptr_q + PTR_W'(1);
    assign cmd_legal = cmd_rsv_ok(bus.byte_in) && (32'(cmd_addr) < 32'(NUM_REGS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            regs_q     <= {NUM_REGS{RESET_VAL}};
            tx_data_q  <= 8'h00;
            tx_load_q  <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= 4'h0;
            err_q      <= 4'h0;
            rdy_q      <= 1'b0;
        end else begin
            rdy_q      <= 1'b1;
            tx_load_q  <= 1'b0;
            wr_pulse_q <= 1'b0;
            if (accept) begin
                unique case (state_q)
                    IDLE: if (!cs_s) begin
                        if (cmd_legal) begin
                            ptr_q <= cmd_ptr;
                            if (bus.byte_in[CMD_WR_BIT]) begin
                                state_q <= WR;
                            end else begin
                                state_q   <= RD;
                                tx_data_q <= regs_q[cmd_ptr];
                                tx_load_q <= 1'b1;
                            end
                        end else begin
                            if (err_q != 4'hF) err_q <= err_q + 4'h1;
                            state_q <= DRAIN;
                        end
                    end
                    WR: begin
                        regs_q[ptr_q] <= bus.byte_in;
                        wr_pulse_q    <= 1'b1;
                        wr_addr_q     <= 4'(ptr_q);
                        ptr_q         <= ptr_inc;
                    end
                    RD: begin
                        ptr_q     <= ptr_inc;
                        tx_data_q <= regs_q[ptr_inc];
                        tx_load_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
            // Frame end overrides any transition above; a same-edge write still lands.
            if (state_q != IDLE && cs_s) state_q <= IDLE;
        end
    end

    assign bus.byte_rdy = rdy_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_load  = tx_load_q;
    assign reg_q        = regs_q;
    assign wr_pulse     = wr_pulse_q;
    assign wr_addr      = wr_addr_q;
    assign err_cnt      = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: a command-level model queues expected
// writes and tx loads as bytes are driven; a monitor pops them as the DUT pulses.
module tb_spi_reg_ctrl;
    import spi_pkg::*;

    localparam int NUM_REGS = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  cs  = 1'b1;
    logic [8*NUM_REGS-1:0] reg_q;
    logic                  wr_pulse;
    logic [3:0]            wr_addr;
    logic [3:0]            err_cnt;

    spi_reg_ctrl_if bus();

    spi_reg_ctrl #(.NUM_REGS(NUM_REGS), .RESET_VAL(8'h00)) dut (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs),
        .bus      (bus),
        .reg_q    (reg_q),
        .wr_pulse (wr_pulse),
        .wr_addr  (wr_addr),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef enum {M_IDLE, M_WR, M_RD, M_DRAIN} mstate_e;
    mstate_e    mstate = M_IDLE;
    int         mptr   = 0;
    int         merr   = 0;
    bit         mact   = 1'b0;
    logic [7:0] mregs [NUM_REGS];
    logic [11:0] wq [$];
    logic [7:0]  tq [$];
    logic [11:0] wexp;
    logic [7:0]  texp;

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) mregs[i] = 8'h00;
        mstate = M_IDLE;
        mptr   = 0;
        merr   = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        case (mstate)
            M_IDLE: if (mact) begin
                if (b[6:4] != 3'b000) begin
                    merr   = (merr < 15) ? merr + 1 : 15;
                    mstate = M_DRAIN;
                end else begin
                    mptr = int'(b[3:0]);
                    if (b[7]) mstate = M_WR;
                    else begin
                        mstate = M_RD;
                        tq.push_back(mregs[mptr]);
                    end
                end
            end
            M_WR: begin
                mregs[mptr] = b;
                wq.push_back({4'(mptr), b});
                mptr = (mptr + 1) % NUM_REGS;
            end
            M_RD: begin
                mptr = (mptr + 1) % NUM_REGS;
                tq.push_back(mregs[mptr]);
            end
            default: ;
        endcase
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.byte_in  = b;
        bus.byte_val = 1'b1;
        model_byte(b);
        @(negedge clk);
        bus.byte_val = 1'b0;
    endtask

    task automatic frame_open();
        @(negedge clk);
        cs = 1'b0;
        repeat (3) @(negedge clk);
        mact = 1'b1;
    endtask

    task automatic frame_close();
        @(negedge clk);
        cs     = 1'b1;
        mact   = 1'b0;
        mstate = M_IDLE;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NUM_REGS; i++)
            chk($sformatf("%s_reg%0d", tag, i), 32'(reg_q[8*i +: 8]), 32'(mregs[i]));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_pulse) begin
                chk("wr_expected", 32'(wq.size() > 0), 1);
                if (wq.size() > 0) begin
                    wexp = wq.pop_front();
                    chk("wr_addr", 32'(wr_addr), 32'(wexp[11:8]));
                    chk("wr_data", 32'(reg_q[8*wr_addr +: 8]), 32'(wexp[7:0]));
                end
            end
            if (bus.tx_load) begin
                chk("tx_expected", 32'(tq.size() > 0), 1);
                if (tq.size() > 0) begin
                    texp = tq.pop_front();
                    chk("tx_data", 32'(bus.tx_data), 32'(texp));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        bus.byte_in  = 8'h00;
        bus.byte_val = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_regs",     32'(reg_q == '0), 1);
        chk("rst_err",      32'(err_cnt), 0);
        chk("rst_wr_pulse", 32'(wr_pulse), 0);
        chk("rst_wr_addr",  32'(wr_addr), 0);
        chk("rst_tx_load",  32'(bus.tx_load), 0);
        chk("rst_tx_data",  32'(bus.tx_data), 0);
        chk("rst_rdy",      32'(bus.byte_rdy), 0);
        chk("rst_state",    32'(dut.state_q), 32'(IDLE));
        rst = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst", 32'(bus.byte_rdy), 1);

        // Write burst
        frame_open();
        send(8'h82); send(8'hAA); send(8'hBB);
        frame_close();
        chk("wb_reg2", 32'(reg_q[8*2 +: 8]), 32'hAA);
        chk("wb_reg3", 32'(reg_q[8*3 +: 8]), 32'hBB);
        chk("wb_err",  32'(err_cnt), 0);
        chk("wb_drained", 32'(wq.size()), 0);

        // Preset with wrapping write, then read burst with wrap
        frame_open();
        send(8'h8F); send(8'h5C); send(8'h11);
        frame_close();
        chk("pre_reg15", 32'(reg_q[8*15 +: 8]), 32'h5C);
        chk("pre_reg0",  32'(reg_q[7:0]), 32'h11);
        frame_open();
        send(8'h0F); send(8'h00); send(8'hFF);
        frame_close();
        chk("rd_drained", 32'(tq.size()), 0);

        // Byte while cs high is discarded
        send(8'h85);
        repeat (2) @(negedge clk);
        chk("discard_state", 32'(dut.state_q), 32'(IDLE));

        // Frame boundary re-decodes command
        frame_open();
        send(8'h81); send(8'h44);
        frame_close();
        frame_open();
        send(8'h81); send(8'h55);
        frame_close();
        chk("fb_reg1", 32'(reg_q[8*1 +: 8]), 32'h55);
        check_regs("fb");

        // Byte accept on the same edge the synchronized cs is seen high
        frame_open();
        send(8'h84);
        @(negedge clk);
        cs = 1'b1;
        @(negedge clk);
        send(8'h7E);
        chk("sim_state", 32'(dut.state_q), 32'(IDLE));
        chk("sim_reg4",  32'(reg_q[8*4 +: 8]), 32'h7E);
        mact   = 1'b0;
        mstate = M_IDLE;
        repeat (3) @(negedge clk);

        // Illegal command
        frame_open();
        send(8'h90); send(8'h33);
        chk("ill_state_drain", 32'(dut.state_q), 32'(DRAIN));
        chk("ill_err1", 32'(err_cnt), 1);
        frame_close();
        chk("ill_state_idle", 32'(dut.state_q), 32'(IDLE));
        check_regs("ill");
        for (int n = 0; n < 19; n++) begin
            frame_open();
            send(8'h90); send(8'h33);
            frame_close();
            chk($sformatf("ill_err_%0d", n), 32'(err_cnt), 32'(merr));
        end
        chk("ill_err_sat", 32'(err_cnt), 15);

        // Reset mid-frame
        frame_open();
        send(8'h81);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        chk("mr_regs_clear", 32'(reg_q == '0), 1);
        chk("mr_err_clear",  32'(err_cnt), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send(8'h83); send(8'h99);
        frame_close();
        chk("mr_reg3", 32'(reg_q[8*3 +: 8]), 32'h99);
        check_regs("mr");

        chk("end_wq", 32'(wq.size()), 0);
        chk("end_tq", 32'(tq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Command sequencer behind the SPI byte receiver. It consumes the receiver's byte stream (data/val/rdy) and decodes each chip-select frame as a command byte followed by data bytes. It executes register writes and reads against a local register file, and presents read data to the transmit side. It sits between the SPI byte receiver and the design's configuration fabric; all register state lives here.

## Interface
Parameters:
- NUM_REGS, 16, number of 8-bit registers; power of two, 2..16.
- RESET_VAL, 8'h00, reset value of every register.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- cs  input  1  raw SPI chip select, active low, asynchronous to clk.
- byte_in  input  8  byte from the receiver.
- byte_val  input  1  byte_in valid.
- byte_rdy  output  1  controller can accept a byte.
- tx_data  output  8  next byte to shift out on MISO.
- tx_load  output  1  one-cycle pulse: tx_data is fresh.
- reg_q  output  8*NUM_REGS  flattened register file; register i is bits [8i+7:8i].
- wr_pulse  output  1  one-cycle pulse on each register write.
- wr_addr  output  4  address written on wr_pulse.
- err_cnt  output  4  saturating count of illegal commands.

## Operation
- cs passes through a 2-flop synchronizer (cs_s), reset to 1. A frame is active while cs_s == 0.
- A byte is accepted on any edge where byte_val & byte_rdy.
- byte_rdy = 1 in every state except during rst.
- Command byte format: bit7 = 1 write / 0 read; bits[6:4] must be 0; bits[3:0] = start address.
- An address ≥ NUM_REGS is illegal. A reserved bit set is illegal.
- FSM states:
  - IDLE: a byte accepted with cs_s == 0 is decoded as the command.
    - Legal write: ptr ← addr, go to WR.
    - Legal read: ptr ← addr, go to RD, and load tx from reg[addr].
    - Illegal: err_cnt += 1 (saturates at 15), go to DRAIN.
    - Bytes accepted while cs_s == 1 are discarded.
  - WR: each accepted byte writes reg[ptr] ← byte_in, pulses wr_pulse with wr_addr = ptr, then ptr ← ptr+1.
  - RD: each accepted byte is a dummy and is ignored. It advances ptr ← ptr+1 and loads tx from reg[ptr+1].
  - DRAIN: accepted bytes are discarded.
- In WR, RD and DRAIN, cs_s rising (frame end) returns the FSM to IDLE.
- Address arithmetic: ptr is log2(NUM_REGS) bits wide and wraps modulo NUM_REGS, so 15 → 0 when NUM_REGS = 16.
- A "tx load" sets tx_data and pulses tx_load for one cycle.

## Timing
- Reset values: state IDLE, ptr 0, all registers RESET_VAL, tx_data 8'h00, tx_load 0, wr_pulse 0, wr_addr 0, err_cnt 0, byte_rdy 0.
- Write latency: a byte accepted at edge k updates reg_q, wr_pulse and wr_addr at edge k. These are visible in cycle k+1.
- Read latency: tx_data/tx_load are registered at the edge that accepts the command or dummy byte. tx_load is high for exactly the following cycle.
- Frame end: a raw cs rise is seen by the FSM 2 edges later. The state is IDLE by the 3rd edge.
- Simultaneous byte accept and frame end on the same edge: the byte is processed per the current state, then the state is forced to IDLE. A write still lands.
- Frame start needs no action. IDLE already treats the first in-frame byte as the command.
- Asynchronous rst mid-frame: all state is cleared immediately. The remaining bytes of that frame are decoded as if the frame had just started, meaning the first byte after rst deasserts is the command.
- err_cnt holds at 15 and never wraps.

## Structure
- Shared package spi_pkg holds:
  - Command field constants: CMD_WR_BIT = 7, CMD_RSV_MSB = 6, CMD_RSV_LSB = 4, CMD_ADDR_W = 4.
  - FSM state encoding: IDLE, WR, RD, DRAIN.
- One sub-module is natural: sync_2ff (the cs synchronizer), with a parameterized reset value. It is reused by other cross-domain inputs.
- The register file is inline: a flop array with asynchronous reset.

## Test plan
- Write burst: rst, then frame 0x82, 0xAA, 0xBB → reg2 = 0xAA and reg3 = 0xBB. wr_pulse fires twice with wr_addr 2 then 3. err_cnt stays 0.
- Read burst with wrap: preset reg15 = 0x5C and reg0 = 0x11; frame 0x0F, dummy → tx_load pulses with tx_data 0x5C, then 0x11.
- Illegal command: frame 0x90, 0x33 → no writes, err_cnt = 1, FSM in DRAIN until cs rises, then IDLE. Repeating this 20 times leaves err_cnt = 15.
- Frame boundary: frame 0x81, 0x44, cs high, new frame 0x81, 0x55 → reg1 = 0x55. The second 0x81 is decoded as a command, not data.
- Simultaneous events: the byte 0x7E is accepted on the same edge the synchronized cs rises in WR at ptr 4 → reg4 = 0x7E and the state is IDLE next cycle.
- Reset mid-frame: assert rst after a write command byte, release, and send 0x83, 0x99 in the same cs-low period → all registers RESET_VAL, then reg3 = 0x99.
